// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared definitions for the UART receiver: receiver state
//             encoding, frame data width and the default bit period.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Number of data bits carried by one 8N1 frame.
   localparam int DATA_BITS = 8;

   // Clock cycles per bit period: 50 MHz system clock, 115200 baud.
   localparam int SAMPLE_COUNT_DEFAULT = 434;

   // Receiver states, explicitly 2 bits wide.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sync2
//  Purpose  : Two-flop synchronizer that brings the asynchronous serial line
//             into the clk domain. Both flops reset to 1 (line idle level).
//  Ports    : clk   - system clock, rising edge
//             reset - synchronous, active-low reset
//             d     - asynchronous input
//             q     - synchronized output
//  Revision : 1.0 - initial release
// ============================================================================
module uart_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule : uart_sync2
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver. Detects the start bit on the synchronized
//             line, re-checks it at mid bit, samples 8 data bits (LSB first)
//             and the stop bit at their centres, and publishes the byte with
//             a one-cycle ready strobe when the stop bit is valid.
//  Ports    : clk   - system clock, rising edge
//             reset - synchronous, active-low reset
//             rx    - asynchronous serial input, idles high
//             data  - last correctly received byte (registered)
//             ready - one-cycle strobe, data newly valid
//  Params   : SAMPLE_COUNT - clock cycles per bit period (4..65535)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx
   import uart_pkg::*;
#(
   parameter int SAMPLE_COUNT = SAMPLE_COUNT_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       ready
);

   localparam int CW = $clog2(SAMPLE_COUNT);

   // Terminal counts: centre of the start bit, and one full bit period.
   localparam logic [CW-1:0] c_HALF_LAST = CW'(SAMPLE_COUNT / 2 - 1);
   localparam logic [CW-1:0] c_BIT_LAST  = CW'(SAMPLE_COUNT - 1);
   localparam logic [2:0]    c_IDX_LAST  = 3'(DATA_BITS - 1);

   logic                 rx_s;

   uart_state_e          state_q,     state_d;
   logic [CW-1:0]        cnt_q,       cnt_d;
   logic [2:0]           idx_q,       idx_d;
   logic [DATA_BITS-1:0] shift_q,     shift_d;
   logic [7:0]           data_q,      data_d;
   logic                 ready_q,     ready_d;
   // Blocks start detection until the line has been seen high. Set after a
   // framing error (so a held-low break yields only one bad frame) and out
   // of reset (so a line already low at release is not taken as a start).
   logic                 wait_high_q, wait_high_d;

   uart_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      ready_d     = 1'b0;
      wait_high_d = wait_high_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (wait_high_q) begin
               if (rx_s) begin
                  wait_high_d = 1'b0;
               end
            end else if (!rx_s) begin
               state_d = START;
            end
         end

         START: begin
            if (cnt_q == c_HALF_LAST) begin
               cnt_d = '0;
               idx_d = '0;
               // Still low at mid bit: genuine start. High: glitch, drop it.
               state_d = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         DATA: begin
            if (cnt_q == c_BIT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               if (idx_q == c_IDX_LAST) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         STOP: begin
            if (cnt_q == c_BIT_LAST) begin
               // Leaving at mid stop bit leaves half a bit of margin to catch
               // a start bit that follows immediately.
               cnt_d   = '0;
               state_d = IDLE;
               if (rx_s) begin
                  data_d  = shift_q;
                  ready_d = 1'b1;
               end else begin
                  wait_high_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         data_q      <= 8'h00;
         ready_q     <= 1'b0;
         wait_high_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         ready_q     <= ready_d;
         wait_high_q <= wait_high_d;
      end
   end

   assign data  = data_q;
   assign ready = ready_q;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx. One instance at the default
//             bit period, one with SAMPLE_COUNT overridden to 16. Expected
//             bytes and strobe times are queued as frames are driven and
//             popped when ready fires.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

   localparam int SC_A = 434;
   localparam int SC_B = 16;

   typedef struct {
      logic [7:0] d;
      int         t;
   } exp_t;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic       rx_a  = 1'b1;
   logic       rx_b  = 1'b1;
   logic [7:0] data_a, data_b;
   logic       ready_a, ready_b;

   int   cyc     = 0;
   int   n_total = 0;
   int   n_pass  = 0;
   int   cnt_a   = 0;
   int   cnt_b   = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx dut_a (
      .clk   (clk),
      .reset (reset),
      .rx    (rx_a),
      .data  (data_a),
      .ready (ready_a)
   );

   uart_rx #(.SAMPLE_COUNT(SC_B)) dut_b (
      .clk   (clk),
      .reset (reset),
      .rx    (rx_b),
      .data  (data_b),
      .ready (ready_b)
   );

   // Scoreboard monitors: sample at negedge, pop one expectation per strobe.
   initial begin : mon_a
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (ready_a) begin
            cnt_a++;
            if (prev) begin
               n_total++;
               $display("FAIL ready_a_double cycle=%0d ready high 2 cycles, required 1", cyc);
            end
            if (q_a.size() == 0) begin
               n_total++;
               $display("FAIL ready_a_unexpected data=%02h cycle=%0d required no strobe", data_a, cyc);
            end else begin
               e = q_a.pop_front();
               n_total++;
               if (data_a !== e.d) $display("FAIL sb_a_data actual=%02h required=%02h", data_a, e.d);
               else n_pass++;
               n_total++;
               if (cyc < e.t - 1 || cyc > e.t + 1)
                  $display("FAIL sb_a_time actual=%0d required=%0d+-1", cyc, e.t);
               else n_pass++;
            end
         end
         prev = ready_a;
      end
   end

   initial begin : mon_b
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (ready_b) begin
            cnt_b++;
            if (prev) begin
               n_total++;
               $display("FAIL ready_b_double cycle=%0d ready high 2 cycles, required 1", cyc);
            end
            if (q_b.size() == 0) begin
               n_total++;
               $display("FAIL ready_b_unexpected data=%02h cycle=%0d required no strobe", data_b, cyc);
            end else begin
               e = q_b.pop_front();
               n_total++;
               if (data_b !== e.d) $display("FAIL sb_b_data actual=%02h required=%02h", data_b, e.d);
               else n_pass++;
               n_total++;
               if (cyc < e.t - 1 || cyc > e.t + 1)
                  $display("FAIL sb_b_time actual=%0d required=%0d+-1", cyc, e.t);
               else n_pass++;
            end
         end
         prev = ready_b;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input int sel, input logic v, input int n);
      if (sel == 0) rx_a = v;
      else          rx_b = v;
      wait_cyc(n);
   endtask

   // Strobe expected at (first edge seeing rx low) + SC/2 + 9*SC + 3.
   task automatic send_frame(input int sel, input logic [7:0] b, input logic stop_v,
                             input bit exp_rdy);
      int   sc;
      exp_t e;
      sc = (sel == 0) ? SC_A : SC_B;
      if (exp_rdy) begin
         e.d = b;
         e.t = cyc + 1 + sc / 2 + 9 * sc + 3;
         if (sel == 0) q_a.push_back(e);
         else          q_b.push_back(e);
      end
      drive_bit(sel, 1'b0, sc);
      for (int i = 0; i < 8; i++) drive_bit(sel, b[i], sc);
      drive_bit(sel, stop_v, sc);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      rx_a  = 1'b1;
      rx_b  = 1'b1;
      #500;
      n_total++;
      if (data_a !== 8'h00 || ready_a !== 1'b0)
         $display("FAIL reset_hold_a data=%02h ready=%b required 00/0", data_a, ready_a);
      else n_pass++;
      n_total++;
      if (data_b !== 8'h00 || ready_b !== 1'b0)
         $display("FAIL reset_hold_b data=%02h ready=%b required 00/0", data_b, ready_b);
      else n_pass++;
      #500;
      @(posedge clk);
      #1;
      reset = 1'b1;
      wait_cyc(50);
      n_total++;
      if (data_a !== 8'h00 || cnt_a !== 0)
         $display("FAIL reset_release_a data=%02h strobes=%0d required 00/0", data_a, cnt_a);
      else n_pass++;
      n_total++;
      if (data_b !== 8'h00 || cnt_b !== 0)
         $display("FAIL reset_release_b data=%02h strobes=%0d required 00/0", data_b, cnt_b);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [4];
      bytes[0] = 8'h55; bytes[1] = 8'hAA; bytes[2] = 8'hF0; bytes[3] = 8'h0F;
      for (int i = 0; i < 4; i++) send_frame(0, bytes[i], 1'b1, 1'b1);
      drive_bit(0, 1'b1, SC_A);
      n_total++;
      if (q_a.size() != 0) $display("FAIL b2b_drain pending=%0d required 0", q_a.size());
      else n_pass++;
      n_total++;
      if (cnt_a !== 4) $display("FAIL b2b_count actual=%0d required=4", cnt_a);
      else n_pass++;
      n_total++;
      if (data_a !== 8'h0F) $display("FAIL b2b_data actual=%02h required=0f", data_a);
      else n_pass++;
   endtask

   task automatic test_glitch();
      drive_bit(0, 1'b0, SC_A / 4);
      drive_bit(0, 1'b1, 2 * SC_A);
      n_total++;
      if (cnt_a !== 4 || data_a !== 8'h0F)
         $display("FAIL glitch_reject strobes=%0d data=%02h required 4/0f", cnt_a, data_a);
      else n_pass++;
      send_frame(0, 8'h3C, 1'b1, 1'b1);
      drive_bit(0, 1'b1, SC_A);
      n_total++;
      if (q_a.size() != 0 || cnt_a !== 5)
         $display("FAIL glitch_frame pending=%0d strobes=%0d required 0/5", q_a.size(), cnt_a);
      else n_pass++;
      n_total++;
      if (data_a !== 8'h3C) $display("FAIL glitch_data actual=%02h required=3c", data_a);
      else n_pass++;
   endtask

   task automatic test_framing();
      send_frame(0, 8'hA5, 1'b0, 1'b0);
      drive_bit(0, 1'b1, SC_A);
      n_total++;
      if (cnt_a !== 5 || data_a !== 8'h3C)
         $display("FAIL framing_discard strobes=%0d data=%02h required 5/3c", cnt_a, data_a);
      else n_pass++;
      send_frame(0, 8'h5A, 1'b1, 1'b1);
      drive_bit(0, 1'b1, SC_A);
      n_total++;
      if (q_a.size() != 0 || cnt_a !== 6 || data_a !== 8'h5A)
         $display("FAIL framing_recover pending=%0d strobes=%0d data=%02h required 0/6/5a",
                  q_a.size(), cnt_a, data_a);
      else n_pass++;
   endtask

   task automatic test_reset_midframe();
      drive_bit(0, 1'b0, SC_A);
      for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, SC_A);
      drive_bit(0, 1'b1, SC_A / 2);
      reset = 1'b0;
      wait_cyc(4);
      n_total++;
      if (data_a !== 8'h00 || ready_a !== 1'b0)
         $display("FAIL midreset_hold data=%02h ready=%b required 00/0", data_a, ready_a);
      else n_pass++;
      reset = 1'b1;
      wait_cyc(SC_A - SC_A / 2 - 4);
      for (int i = 5; i < 8; i++) drive_bit(0, 1'b1, SC_A);
      drive_bit(0, 1'b1, SC_A);
      drive_bit(0, 1'b1, SC_A);
      n_total++;
      if (cnt_a !== 6 || data_a !== 8'h00)
         $display("FAIL midreset_abort strobes=%0d data=%02h required 6/00", cnt_a, data_a);
      else n_pass++;
      send_frame(0, 8'h81, 1'b1, 1'b1);
      drive_bit(0, 1'b1, SC_A);
      n_total++;
      if (q_a.size() != 0 || cnt_a !== 7 || data_a !== 8'h81)
         $display("FAIL midreset_recover pending=%0d strobes=%0d data=%02h required 0/7/81",
                  q_a.size(), cnt_a, data_a);
      else n_pass++;
   endtask

   task automatic test_break();
      drive_bit(0, 1'b0, 12 * SC_A);
      drive_bit(0, 1'b1, 2 * SC_A);
      n_total++;
      if (cnt_a !== 7 || data_a !== 8'h81)
         $display("FAIL break_quiet strobes=%0d data=%02h required 7/81", cnt_a, data_a);
      else n_pass++;
      send_frame(0, 8'h66, 1'b1, 1'b1);
      drive_bit(0, 1'b1, SC_A);
      n_total++;
      if (q_a.size() != 0 || cnt_a !== 8 || data_a !== 8'h66)
         $display("FAIL break_recover pending=%0d strobes=%0d data=%02h required 0/8/66",
                  q_a.size(), cnt_a, data_a);
      else n_pass++;
   endtask

   task automatic test_param();
      send_frame(1, 8'hC3, 1'b1, 1'b1);
      n_total++;
      if (data_b !== 8'hC3) $display("FAIL param_data actual=%02h required=c3", data_b);
      else n_pass++;
      send_frame(1, 8'h96, 1'b1, 1'b1);
      drive_bit(1, 1'b1, 2 * SC_B);
      n_total++;
      if (q_b.size() != 0 || cnt_b !== 2 || data_b !== 8'h96)
         $display("FAIL param_b2b pending=%0d strobes=%0d data=%02h required 0/2/96",
                  q_b.size(), cnt_b, data_b);
      else n_pass++;
      n_total++;
      if (cnt_a !== 8) $display("FAIL param_isolation strobes_a=%0d required=8", cnt_a);
      else n_pass++;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      test_reset();
      test_back_to_back();
      test_glitch();
      test_framing();
      test_reset_midframe();
      test_break();
      test_param();
      wait_cyc(4);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_uart_rx
`default_nettype wire
